// File: rtl/argmax_select_pkg.sv
// Shared defaults and state encoding for the argmax selector.
package argmax_select_pkg;

  // Number of class scores per vector.
  localparam int DEF_N          = 10;
  // Score width; matches the output width of the upstream vector-matrix product stage.
  localparam int DEF_VALUE_SIZE = 26;
  // Index width, $clog2(DEF_N).
  localparam int DEF_IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_select_if.sv
// Upstream vector handshake plus downstream result handshake for argmax_select.
interface argmax_select_if
  import argmax_select_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int VALUE_SIZE = DEF_VALUE_SIZE,
  parameter int IDX_W      = DEF_IDX_W
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [VALUE_SIZE*N-1:0] Scores;
  logic                    out_valid;
  logic                    out_ready;
  logic [IDX_W-1:0]        ClassIdx;
  logic [VALUE_SIZE-1:0]   MaxValue;

  modport master (
    output in_valid, Scores, out_ready,
    input  in_ready, out_valid, ClassIdx, MaxValue
  );

  modport slave (
    input  in_valid, Scores, out_ready,
    output in_ready, out_valid, ClassIdx, MaxValue
  );

endinterface

// File: rtl/argmax_select.sv
// Sequential argmax: captures N signed scores, scans one per cycle, holds the result until accepted.
module argmax_select
  import argmax_select_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int VALUE_SIZE = DEF_VALUE_SIZE,
  parameter int IDX_W      = DEF_IDX_W
) (
  input  logic            clk,
  input  logic            GlobalReset,
  argmax_select_if.slave  bus
);

  state_t                       state, state_nxt;
  logic signed [VALUE_SIZE-1:0] score_q [N];
  logic signed [VALUE_SIZE-1:0] best_val;
  logic signed [VALUE_SIZE-1:0] cand;
  logic [IDX_W-1:0]             best_idx;
  logic [IDX_W-1:0]             cnt;
  logic                         last;
  logic                         in_ready;
  logic                         out_valid;

  assign cand = score_q[cnt];
  assign last = (cnt == IDX_W'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = SCAN;
      end
      SCAN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Score capture and running maximum; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      for (int unsigned i = 0; i < N; i++) score_q[i] <= '0;
      best_val <= '0;
      best_idx <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int unsigned i = 0; i < N; i++)
              score_q[i] <= bus.Scores[i*VALUE_SIZE +: VALUE_SIZE];
            best_val <= bus.Scores[VALUE_SIZE-1:0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
          end
        end
        SCAN: begin
          if (cand > best_val) begin
            best_val <= cand;
            best_idx <= cnt;
          end
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.ClassIdx  = best_idx;
  assign bus.MaxValue  = best_val;

endmodule

// File: doc/argmax_select.md
ARGMAX_SELECT -- requirements
Module: argmax_select

Interface
REQ-001 Parameter N, default 10, number of class scores per vector (SHALL be >= 2).
REQ-002 Parameter VALUE_SIZE, default 26, width of each score.
REQ-003 Parameter IDX_W, default 4, index width, SHALL equal $clog2(N).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 GlobalReset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  Scores holds a valid vector.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 Scores  input  VALUE_SIZE*N  packed scores; score j at bits [(j+1)*VALUE_SIZE-1 : j*VALUE_SIZE], two's-complement signed.
REQ-009 out_valid  output  1  ClassIdx/MaxValue valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 ClassIdx  output  IDX_W  index of the largest score.
REQ-012 MaxValue  output  VALUE_SIZE  largest score, signed.

Function
REQ-013 States SHALL be IDLE, SCAN, DONE.
REQ-014 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-015 Accept edge (IDLE, in_valid=1): register all N scores, best_val=score[0], best_idx=0, cnt=1, go to SCAN; Scores ignored thereafter until next IDLE.
REQ-016 Each SCAN edge: if score[cnt] > best_val (signed, strict), best_val=score[cnt], best_idx=cnt; cnt increments.
REQ-017 SCAN edge with cnt=N-1 SHALL perform its compare and go to DONE; out_valid rises N-1 edges after the accept edge (9 for N=10).
REQ-018 Ties SHALL resolve to the lowest index (strict compare).
REQ-019 Comparison SHALL be full VALUE_SIZE signed; no truncation, saturation, or widening of MaxValue.
REQ-020 In DONE, ClassIdx/MaxValue SHALL be held stable until the edge where out_ready=1, then go to IDLE.
REQ-021 in_valid=1 while in SCAN or DONE SHALL have no effect (in_ready=0); upstream holds.
REQ-022 Minimum vector-to-vector period SHALL be N+1 cycles (accept, N-1 scans, >=1 DONE cycle).
REQ-023 ClassIdx/MaxValue outside DONE are don't-care for consumers but SHALL only change on accept/SCAN edges.

Reset
REQ-024 GlobalReset=0 SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, ClassIdx=0, MaxValue=0, cnt=0, score registers=0.
REQ-025 Reset during SCAN or DONE SHALL abandon the vector; no result emitted; first vector after release processed normally.

Structure
REQ-026 Shared package SHALL hold N, VALUE_SIZE, IDX_W defaults and the IDLE/SCAN/DONE state encoding; VALUE_SIZE SHALL match the score width produced by the upstream vector-matrix product stage.
REQ-027 Single module; signed compare inline, no sub-module; score storage is an N-entry register array indexed by cnt.

Verification
REQ-028 score[j]=j (j=0..9), out_ready=1 -> ClassIdx=9, MaxValue=9, out_valid exactly 9 cycles after accept, one cycle wide.
REQ-029 All scores=100 -> ClassIdx=0, MaxValue=100; scores {5,7,7,...,0} -> ClassIdx=1.
REQ-030 All scores=-5 except score[3]=-1 -> ClassIdx=3, MaxValue=-1; score[0]=0x1FFFFFF, others 0x2000000 -> ClassIdx=0.
REQ-031 out_ready=0 for 5 cycles in DONE -> out_valid, ClassIdx, MaxValue stable, in_ready=0; IDLE on cycle after out_ready=1.
REQ-032 GlobalReset=0 asserted on 4th SCAN cycle -> out_valid=0, no result; after release vector score[j]=9-j -> ClassIdx=0, MaxValue=9.
REQ-033 Two vectors with in_valid held high -> second accepted on the cycle after first handshake, both results correct, in order.
